// File: rtl/register_bank_2r1w.sv
// register_bank_2r1w: 32 x 32-bit general-purpose register bank with two
// registered read ports and one write port, feeding the ALU operand path.
//
// Optional build macro: REGFILE_R0_ZERO_EN
//   defined   -> register 0 reads as zero and writes to it are dropped
//   undefined -> register 0 is an ordinary read/write register
//
// Read handshake: READ is a one-cycle request with no back-pressure. The
// edge that samples READ=1 captures both read ports. On the following
// cycle, DATA_R1/DATA_R2 hold the captured words and RD_VALID is 1.
// RD_VALID follows READ with one cycle of delay, so back-to-back reads keep
// it high. DATA_R1/DATA_R2 keep their last captured value until the next
// READ.
//
// Reads are read-before-write: a READ and WRITE to the same address on the
// same edge return the old contents.

module register_bank_2r1w #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int REG_COUNT  = 32   // must equal 2**ADDR_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDR_R1,
    input  logic [ADDR_WIDTH-1:0] ADDR_R2,
    input  logic [ADDR_WIDTH-1:0] ADDR_W,
    input  logic [DATA_WIDTH-1:0] DATA_W,
    output logic [DATA_WIDTH-1:0] DATA_R1,
    output logic [DATA_WIDTH-1:0] DATA_R2,
    output logic                  RD_VALID
);

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] rd1_word;
    logic [DATA_WIDTH-1:0] rd2_word;

    // Write qualification: with a hardwired zero register, writes to 0 are dropped.
    always_comb begin
        wr_en = WRITE;
`ifdef REGFILE_R0_ZERO_EN
        if (ADDR_W == '0) begin
            wr_en = 1'b0;
        end
`endif
    end

    // Storage array: async clear, otherwise load one decoded word per write.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[ADDR_W] <= DATA_W;
        end
    end

    // Read muxes: select the current (pre-write) contents for each port.
    always_comb begin
        rd1_word = regs[ADDR_R1];
        rd2_word = regs[ADDR_R2];
`ifdef REGFILE_R0_ZERO_EN
        if (ADDR_R1 == '0) begin
            rd1_word = '0;
        end
        if (ADDR_R2 == '0) begin
            rd2_word = '0;
        end
`endif
    end

    // Output registers: capture both ports on READ, hold otherwise.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            DATA_R1 <= '0;
            DATA_R2 <= '0;
        end else if (READ) begin
            DATA_R1 <= rd1_word;
            DATA_R2 <= rd2_word;
        end
    end

    // Read-valid flag: one-cycle delayed copy of READ.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RD_VALID <= 1'b0;
        end else begin
            RD_VALID <= READ;
        end
    end

endmodule
